// File: rtl/bmc_soft_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bmc_soft_pipe
// Function : two-stage pipelined soft/hard branch-metric unit for rate-1/N_SYM
//            codes, with erasures, all-hypothesis metrics, min and argmin.
// Revision : 1.0  initial release
// ============================================================================
module bmc_soft_pipe #(
  parameter int N_SYM     = 2,
  parameter int SOFT_W    = 3,
  parameter int HARD_MODE = 0,
  localparam int NH       = 1 << N_SYM,
  localparam int BM_W     = SOFT_W + $clog2(N_SYM) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_SYM*SOFT_W-1:0] rx_sym,
  input  logic [N_SYM-1:0]        rx_era,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NH*BM_W-1:0]      bm_out,
  output logic [BM_W-1:0]         bm_min,
  output logic [N_SYM-1:0]        bm_min_idx,
  output logic                    out_last,
  output logic [15:0]             branch_cnt
);

  logic [SOFT_W-1:0] w_c0 [N_SYM];
  logic [SOFT_W-1:0] w_c1 [N_SYM];

  logic              r_v1;
  logic              r_last1;
  logic [SOFT_W-1:0] r_c0 [N_SYM];
  logic [SOFT_W-1:0] r_c1 [N_SYM];

  logic              r_v2;
  logic              r_last2;
  logic [NH*BM_W-1:0] r_bm;
  logic [BM_W-1:0]   r_min;
  logic [N_SYM-1:0]  r_idx;
  logic [15:0]       r_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic [BM_W-1:0]   w_bm [NH];
  logic [NH*BM_W-1:0] w_bm_flat;
  logic [BM_W-1:0]   w_min;
  logic [N_SYM-1:0]  w_idx;

  assign w_s2_adv = !r_v2 || out_ready;
  assign w_s1_adv = !r_v1 || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Per-symbol costs; in soft mode SMAX - s is simply the bitwise inverse of s.
  for (genvar j = 0; j < N_SYM; j++) begin : g_sym
    logic [SOFT_W-1:0] w_s;
    assign w_s = rx_sym[j*SOFT_W +: SOFT_W];
    if (HARD_MODE != 0) begin : g_hard
      logic w_h;
      logic w_hn;
      assign w_h     = w_s[SOFT_W-1];
      assign w_hn    = ~w_h;
      assign w_c0[j] = rx_era[j] ? '0 : SOFT_W'(w_h);
      assign w_c1[j] = rx_era[j] ? '0 : SOFT_W'(w_hn);
    end else begin : g_soft
      assign w_c0[j] = rx_era[j] ? '0 : w_s;
      assign w_c1[j] = rx_era[j] ? '0 : ~w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      for (int j = 0; j < N_SYM; j++) begin
        r_c0[j] <= '0;
        r_c1[j] <= '0;
      end
    end else if (w_s1_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_last1 <= in_last;
        for (int j = 0; j < N_SYM; j++) begin
          r_c0[j] <= w_c0[j];
          r_c1[j] <= w_c1[j];
        end
      end
    end
  end

  // Bit j of hypothesis k selects the expected bit for symbol j.
  always_comb begin
    w_bm_flat = '0;
    for (int k = 0; k < NH; k++) begin
      w_bm[k] = '0;
      for (int j = 0; j < N_SYM; j++) begin
        if (((k >> j) & 1) != 0)
          w_bm[k] = w_bm[k] + BM_W'(r_c1[j]);
        else
          w_bm[k] = w_bm[k] + BM_W'(r_c0[j]);
      end
      w_bm_flat[k*BM_W +: BM_W] = w_bm[k];
    end
  end

  // Strict less-than scan: the lowest index keeps a tie.
  always_comb begin
    w_min = w_bm[0];
    w_idx = '0;
    for (int k = 1; k < NH; k++) begin
      if (w_bm[k] < w_min) begin
        w_min = w_bm[k];
        w_idx = N_SYM'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_bm    <= '0;
      r_min   <= '0;
      r_idx   <= '0;
    end else if (w_s2_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_last2 <= r_last1;
        r_bm    <= w_bm_flat;
        r_min   <= w_min;
        r_idx   <= w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (r_v2 && out_ready)
      r_cnt <= r_last2 ? 16'd0 : r_cnt + 16'd1;
  end

  assign out_valid  = r_v2;
  assign out_last   = r_last2 && r_v2;
  assign bm_out     = r_bm;
  assign bm_min     = r_min;
  assign bm_min_idx = r_idx;
  assign branch_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bmc_soft_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmc_soft_pipe
// Function : directed bench for bmc_soft_pipe (soft, hard and wide variants).
// Revision : 1.0  initial release
// ============================================================================
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: N_SYM=2, SOFT_W=3, soft.
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [5:0]  rx_sym = '0;
  logic [1:0]  rx_era = '0;
  logic        out_valid, out_ready = 1'b1, out_last;
  logic [19:0] bm_out;
  logic [4:0]  bm_min;
  logic [1:0]  bm_min_idx;
  logic [15:0] branch_cnt;

  bmc_soft_pipe #(.N_SYM(2), .SOFT_W(3), .HARD_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sym(rx_sym), .rx_era(rx_era), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .bm_out(bm_out),
    .bm_min(bm_min), .bm_min_idx(bm_min_idx), .out_last(out_last),
    .branch_cnt(branch_cnt)
  );

  // Hard-decision instance, fed continuously.
  logic        h_in_ready, h_out_valid, h_out_last;
  logic [5:0]  h_sym = '0;
  logic [19:0] h_bm;
  logic [4:0]  h_min;
  logic [1:0]  h_idx;
  logic [15:0] h_cnt;

  bmc_soft_pipe #(.N_SYM(2), .SOFT_W(3), .HARD_MODE(1)) u_hard (
    .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(h_in_ready),
    .rx_sym(h_sym), .rx_era(2'b00), .in_last(1'b0),
    .out_valid(h_out_valid), .out_ready(1'b1), .bm_out(h_bm),
    .bm_min(h_min), .bm_min_idx(h_idx), .out_last(h_out_last),
    .branch_cnt(h_cnt)
  );

  // Wide instance: N_SYM=3, SOFT_W=4 -> BM_W=7, NH=8.
  logic        x_in_ready, x_out_valid, x_out_last;
  logic [11:0] x_sym = 12'hFFF;
  logic [55:0] x_bm;
  logic [6:0]  x_min;
  logic [2:0]  x_idx;
  logic [15:0] x_cnt;

  bmc_soft_pipe #(.N_SYM(3), .SOFT_W(4), .HARD_MODE(0)) u_wide (
    .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(x_in_ready),
    .rx_sym(x_sym), .rx_era(3'b000), .in_last(1'b0),
    .out_valid(x_out_valid), .out_ready(1'b1), .bm_out(x_bm),
    .bm_min(x_min), .bm_min_idx(x_idx), .out_last(x_out_last),
    .branch_cnt(x_cnt)
  );

  typedef struct {
    logic [2:0]  s0;
    logic [2:0]  s1;
    logic [1:0]  era;
    logic [19:0] bm;
    logic [4:0]  mn;
    logic [1:0]  idx;
  } vec_t;

  vec_t tv [7];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(input int s0, input int s1, input int era,
                              input int b0, input int b1, input int b2,
                              input int b3, input int mn, input int idx);
    vec_t v;
    v.s0  = 3'(s0);
    v.s1  = 3'(s1);
    v.era = 2'(era);
    v.bm  = {5'(b3), 5'(b2), 5'(b1), 5'(b0)};
    v.mn  = 5'(mn);
    v.idx = 2'(idx);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bm_out", bm_out, 0);
    chk("rst_bm_min", bm_min, 0);
    chk("rst_idx", bm_min_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    out_ready = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
  endtask

  // Single group through an idle pipe; leaves time at the negedge after the output transfer.
  task automatic apply(input int i, input logic last);
    @(negedge clk);
    in_valid  = 1'b1;
    rx_sym    = {tv[i].s1, tv[i].s0};
    rx_era    = tv[i].era;
    in_last   = last;
    out_ready = 1'b1;
    #1 chk("apply_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat2_out_valid", out_valid, 1);
    chk("bm_out", bm_out, tv[i].bm);
    chk("bm_min", bm_min, tv[i].mn);
    chk("bm_min_idx", bm_min_idx, tv[i].idx);
    chk("out_last", out_last, last);
    @(posedge clk);
    @(negedge clk);
    chk("drained_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pi, oi, stall_left;
    logic acc, xf;
    logic [19:0] snap;

    //          s0 s1 era  k0 k1 k2 k3  min idx
    tv[0] = mk(0, 7, 0,    7, 14, 0, 7,  0, 2);
    tv[1] = mk(3, 6, 2,    3, 4,  3, 4,  3, 0);
    tv[2] = mk(3, 6, 3,    0, 0,  0, 0,  0, 0);
    tv[3] = mk(7, 7, 0,    14, 7, 7, 0,  0, 3);
    tv[4] = mk(4, 4, 1,    4, 4,  3, 3,  3, 2);
    tv[5] = mk(2, 5, 0,    7, 10, 4, 7,  4, 2);
    tv[6] = mk(3, 4, 0,    7, 8,  6, 7,  6, 2);

    h_sym = {3'd2, 3'd5};
    do_reset();

    // Table of single groups with latency checks.
    for (int i = 0; i < 7; i++) apply(i, 1'b0);

    // Hard mode: s0=5, s1=2 then s0=s1=0.
    chk("hard_bm_52", h_bm, {5'd1, 5'd2, 5'd0, 5'd1});
    chk("hard_min_52", h_min, 0);
    chk("hard_idx_52", h_idx, 1);
    @(negedge clk);
    h_sym = 6'd0;
    repeat (3) @(negedge clk);
    chk("hard_bm_00", h_bm, {5'd2, 5'd1, 5'd1, 5'd0});
    chk("hard_min_00", h_min, 0);
    chk("hard_idx_00", h_idx, 0);

    // Wide: all symbols 15.
    chk("wide_bm", x_bm, {7'd0, 7'd15, 7'd15, 7'd30, 7'd15, 7'd30, 7'd30, 7'd45});
    chk("wide_min", x_min, 0);
    chk("wide_idx", x_idx, 7);

    // Back-to-back stream of 6 with a 4-cycle stall on the first output.
    do_reset();
    pi = 0; oi = 0; stall_left = 4;
    snap = '0;
    for (int cyc = 0; cyc < 80 && oi < 6; cyc++) begin
      @(negedge clk);
      if (pi < 6) begin
        in_valid = 1'b1;
        rx_sym   = {tv[pi].s1, tv[pi].s0};
        rx_era   = tv[pi].era;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == 4) snap = bm_out;
        else chk("stall_hold_bm", bm_out, snap);
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
      end
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf) begin
        chk("stream_bm", bm_out, tv[oi].bm);
        chk("stream_min", bm_min, tv[oi].mn);
        chk("stream_idx", bm_min_idx, tv[oi].idx);
        oi++;
      end
      @(posedge clk);
      if (acc) pi++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_outputs", oi, 6);
    chk("stream_branch_cnt", branch_cnt, 6);

    // Frame of three, last on the third.
    do_reset();
    apply(6, 1'b0);
    chk("frame_cnt_1", branch_cnt, 1);
    apply(0, 1'b0);
    chk("frame_cnt_2", branch_cnt, 2);
    apply(5, 1'b1);
    chk("frame_cnt_0", branch_cnt, 0);

    // Reset with two groups in flight.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rx_sym    = {tv[0].s1, tv[0].s0};
    rx_era    = tv[0].era;
    in_last   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_sym    = {tv[5].s1, tv[5].s0};
    rx_era    = tv[5].era;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_bm_out", bm_out, 0);
    chk("mid_rst_bm_min", bm_min, 0);
    chk("mid_rst_idx", bm_min_idx, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_cnt", branch_cnt, 0);
    out_ready = 1'b1;
    #1 chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
